// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer between the CPU datapath and the data
// memory port. Stores are narrowed to byte/half lanes with byte enables; loads
// are extracted from the returned word and zero/sign-extended to 32 bits.
// Each access is a req/ack transaction aborted after ACK_TIMEOUT REQ cycles.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word accesses
// complete immediately with cpu_err instead of being truncated).
//
// Handshake: cpu_req is sampled only in IDLE; cpu_done is a one-cycle pulse
// qualified by cpu_err; mem_req with its address/enables/data is held stable
// from the cycle after acceptance until mem_ack is sampled high or the timeout
// expires; mem_ack (and mem_rdata) is only looked at while mem_req is high.
module mem_access_unit #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        cpu_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_e;

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        we_q, uns_q;
  logic [1:0]  size_q, off_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        capture;

  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic        misalign_n;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  // Store lane narrowing and misalignment detection from the live request.
  always_comb begin
    be_n = 4'b1111;
    wd_n = 32'd0;
    if (cpu_we) begin
      case (cpu_size)
        2'b00: begin
          be_n = 4'b0001 << cpu_addr[1:0];
          wd_n = {4{cpu_wdata[7:0]}};
        end
        2'b01: begin
          be_n = cpu_addr[1] ? 4'b1100 : 4'b0011;
          wd_n = {2{cpu_wdata[15:0]}};
        end
        default: begin
          be_n = 4'b1111;
          wd_n = cpu_wdata;
        end
      endcase
    end
`ifdef MISALIGN_TRAP_EN
    misalign_n = ((cpu_size == 2'b01) && cpu_addr[0]) ||
                 (cpu_size[1] && (cpu_addr[1:0] != 2'b00));
`else
    misalign_n = 1'b0;
`endif
  end

  // Load lane extraction and extension using the latched access attributes.
  always_comb begin
    ld_b = mem_rdata[{off_q, 3'b000} +: 8];
    ld_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_ext = {{24{~uns_q & ld_b[7]}}, ld_b};
      2'b01:   ld_ext = {{16{~uns_q & ld_h[15]}}, ld_h};
      default: ld_ext = mem_rdata;
    endcase
  end

  // Next-state logic: accept in IDLE, wait for ack or timeout in REQ, pulse DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        err_d = 1'b0;
        if (cpu_req) begin
          capture = 1'b1;
          if (misalign_n) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          if (!we_q) rdata_d = ld_ext;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        err_d   = 1'b0;
      end
    endcase
  end

  // FSM, timeout counter, error flag and load result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Access attributes and memory-side request fields, latched at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      addr_q  <= 32'd0;
      be_q    <= 4'b0000;
      wdata_q <= 32'd0;
    end else if (capture) begin
      we_q    <= cpu_we;
      uns_q   <= cpu_unsigned;
      size_q  <= cpu_size;
      off_q   <= cpu_addr[1:0];
      addr_q  <= {cpu_addr[31:2], 2'b00};
      be_q    <= be_n;
      wdata_q <= wd_n;
    end
  end

  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign cpu_done  = (state_q == S_DONE);
  assign cpu_err   = err_q;
  assign cpu_busy  = (state_q != S_IDLE);
  assign cpu_rdata = rdata_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store data-path sequencer between the CPU datapath and the data memory port. It is the opposite direction of the immediate extender:
- **Stores:** narrows a 32-bit register value to byte or halfword lanes with byte enables.
- **Loads:** extracts the addressed byte or halfword from the returned word and zero- or sign-extends it to 32 bits.

Each access runs as a multi-cycle req/ack transaction with a timeout, so the CPU stalls on `cpu_busy` until `cpu_done`.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 16: max cycles in REQ waiting for `mem_ack` before aborting (range 1..255).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: start access; sampled only in IDLE.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_size` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `cpu_unsigned` in 1: load extension; 1 = zero-extend, 0 = sign-extend.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data; low byte/half used for narrow stores.
- `cpu_rdata` out 32: extended load result, registered.
- `cpu_done` out 1: one-cycle completion pulse.
- `cpu_err` out 1: qualifies `cpu_done`; 1 = timeout, or misalignment when the trap is compiled in.
- `cpu_busy` out 1: high from the cycle after acceptance through DONE.
- `mem_req` out 1: memory request, held until ack or timeout.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: `{cpu_addr[31:2], 2'b00}`.
- `mem_be` out 4: byte enables, bit i selects `[8i+7:8i]`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_ack` in 1: memory completion; read data valid in the same cycle.
- `mem_rdata` in 32: memory read word.

## Operation
- States: IDLE, REQ, DONE. One transaction outstanding at a time.
- **IDLE:**
  - On `cpu_req`=1, latch `cpu_we`, size, unsigned, address offset `off=cpu_addr[1:0]`, the aligned address and `cpu_wdata`.
  - Go to REQ, or to DONE with error (misaligned, trap enabled).
- **REQ:**
  - `mem_req`=1 with registered `mem_we`/`mem_addr`/`mem_be`/`mem_wdata`, all stable until exit.
  - A timeout counter counts REQ cycles.
  - `mem_ack`=1: capture `mem_rdata` (loads), go to DONE, `cpu_err`=0.
  - Counter reaches `ACK_TIMEOUT` with no ack: go to DONE, `cpu_err`=1, `cpu_rdata` unchanged.
- **DONE:** `cpu_done`=1 for exactly one cycle, then IDLE.
- Lanes are little-endian; lane = `off` (byte), `off[1]`*2 (half).
- **Store narrowing:**
  - Byte: `mem_wdata={4{wdata[7:0]}}`, `mem_be=4'b0001<<off`.
  - Half: `mem_wdata={2{wdata[15:0]}}`, `mem_be`=0011 (`off[1]`=0) or 1100.
  - Word: `mem_wdata`=wdata, `mem_be`=1111.
- **Load extension:**
  - Byte: `b=mem_rdata[8*off+:8]`, result `{{24{s&b[7]}},b}`, where s = `!cpu_unsigned`.
  - Half: `h=mem_rdata[16*off[1]+:16]`, result `{{16{s&h[15]}},h}`.
  - Word: result = `mem_rdata`.
- Loads drive `mem_be`=1111 and `mem_wdata`=0.
- `cpu_rdata` updates only on a successful load; stores and errors leave it unchanged.

## Timing
- Reset (async, any state): state=IDLE, counter=0; `mem_req`, `mem_we`, `cpu_done`, `cpu_err`, `cpu_busy`=0; `mem_be`=0000; `mem_addr`, `mem_wdata`, `cpu_rdata`=0.
- An abort mid-REQ drops `mem_req` immediately, and no `cpu_done` is produced.
- `cpu_req` sampled at edge t:
  - `mem_req`=1 from cycle t+1.
  - Ack sampled at edge t+k (k≥1) gives `cpu_done` in cycle t+k+1.
  - IDLE in cycle t+k+2.
  - Minimum latency: 2 cycles from request to done.
- Timeout: with no ack, `cpu_done`/`cpu_err` are asserted in cycle t+`ACK_TIMEOUT`+1.
- An ack on the same edge the counter expires counts as success.
- `mem_ack` outside REQ is ignored.
- `cpu_req` while busy or in DONE is ignored; a request held high is re-accepted in IDLE. Back-to-back issue is therefore every 3 cycles minimum.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are half with `off[0]`=1, or word with `off`≠0.
  - These skip REQ entirely: no `mem_req`, `cpu_done`=`cpu_err`=1 in cycle t+1.
- `MISALIGN_TRAP_EN` undefined:
  - No trap; misaligned offsets are truncated.
  - Half uses `off[1]` only; word uses lane 0 only.
  - The access proceeds normally.

## Test plan
- Load byte, `cpu_addr`=0x1003, signed, `mem_rdata`=0x80FF_0000, ack in the first REQ cycle -> `mem_be`=1111, `mem_addr`=0x1000, `cpu_rdata`=0xFFFF_FF80, `cpu_done` 2 cycles after `cpu_req`.
- Same access with `cpu_unsigned`=1 -> `cpu_rdata`=0x0000_0080.
- Store half, `cpu_addr`=0x2002, `cpu_wdata`=0x1234_ABCD, ack after 3 cycles -> `mem_be`=1100, `mem_wdata`=0xABCD_ABCD, `mem_req` held 3 cycles, single `cpu_done` pulse, `cpu_err`=0.
- Load word, never ack, `ACK_TIMEOUT`=16 -> `mem_req` high 16 cycles, then `cpu_done`=`cpu_err`=1, `cpu_rdata` unchanged.
- Load half at 0x3001:
  - With `MISALIGN_TRAP_EN`: no `mem_req`, `cpu_done`=`cpu_err`=1 in cycle t+1.
  - Without it: `mem_rdata`=0xBEEF_1234 gives `cpu_rdata`=0x0000_1234.
- `rst_n` low during REQ at cycle 5 -> `mem_req`=0 asynchronously, no `cpu_done`; a new load after release completes normally.
